// File: rtl/lc3b_types.sv
// Shared LC-3b type package: bus word type and cache controller states.
package lc3b_types;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  typedef logic [ADDR_W-1:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL
  } lc3b_cache_state;

endpackage

// File: rtl/lc3b_cache_if.sv
// CPU word port plus physical-memory line port of the LC-3b cache.
//   slave  : cache view (takes CPU requests, issues line reads/writes)
//   master : environment view (CPU and physical memory)
interface lc3b_cache_if #(
  parameter int unsigned LINE_BYTES = 16
);
  import lc3b_types::*;

  localparam int unsigned LINE_W = 8 * LINE_BYTES;

  // CPU side
  logic              mem_read;
  logic              mem_write;
  lc3b_word          mem_address;
  lc3b_word          mem_wdata;
  logic [1:0]        mem_byte_enable;
  logic              mem_resp;
  lc3b_word          mem_rdata;

  // Physical memory side
  logic              pmem_read;
  logic              pmem_write;
  lc3b_word          pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output mem_resp, mem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  mem_resp, mem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

endinterface

// File: rtl/cache_array.sv
// Direct-mapped line storage: valid/dirty/tag/data per set.
//   clk, reset : synchronous active-high reset clears valid and dirty
//   idx        : set selected for both the asynchronous read and the write
//   we         : write tag/data, set valid, load dirty from wdirty
//   valid, dirty, tag, data : contents of set idx
module cache_array #(
  parameter int unsigned SETS       = 8,
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned TAG_W      = 9
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [$clog2(SETS)-1:0]   idx,
  input  logic                      we,
  input  logic                      wdirty,
  input  logic [TAG_W-1:0]          wtag,
  input  logic [8*LINE_BYTES-1:0]   wdata,
  output logic                      valid,
  output logic                      dirty,
  output logic [TAG_W-1:0]          tag,
  output logic [8*LINE_BYTES-1:0]   data
);

  localparam int unsigned LINE_W = 8 * LINE_BYTES;

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] data_q [SETS];

  // Status bits: the only state reset has to clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= wdirty;
    end
  end

  // Tag and data are meaningless while invalid, so they carry no reset;
  // a write during reset is still suppressed so an aborted fill leaves no trace.
  always_ff @(posedge clk) begin
    if (!reset && we) begin
      tag_q[idx]  <= wtag;
      data_q[idx] <= wdata;
    end
  end

  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign tag   = tag_q[idx];
  assign data  = data_q[idx];

endmodule

// File: rtl/lc3b_cache.sv
// Direct-mapped write-back, write-allocate cache for the LC-3b core.
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   bus         : CPU word handshake and physical-memory line handshake
//   hit_count   : saturating count of request cycles that hit
//   miss_count  : saturating count of misses (one per missing request)
module lc3b_cache
  import lc3b_types::*;
#(
  parameter int unsigned SETS       = 8,
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  lc3b_cache_if.slave      bus,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int unsigned OFF    = $clog2(LINE_BYTES);
  localparam int unsigned IDX    = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - OFF - IDX;
  localparam int unsigned WSEL_W = OFF - 1;
  localparam int unsigned LINE_W = 8 * LINE_BYTES;

  lc3b_cache_state state_q, state_d;

  // Address split
  logic [IDX-1:0]    idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WSEL_W-1:0] wsel;
  logic [OFF+2:0]    lo_bit;
  logic [OFF+2:0]    hi_bit;
  logic              unused_addr_lsb;

  assign idx             = bus.mem_address[OFF+IDX-1:OFF];
  assign req_tag         = bus.mem_address[ADDR_W-1:OFF+IDX];
  assign wsel            = bus.mem_address[OFF-1:1];
  assign unused_addr_lsb = bus.mem_address[0];
  // Bit offsets of the addressed word's low and high byte within the line.
  assign lo_bit          = {wsel, 4'b0000};
  assign hi_bit          = {wsel, 4'b1000};

  // Array interface
  logic              arr_we;
  logic              arr_wdirty;
  logic [TAG_W-1:0]  arr_wtag;
  logic [LINE_W-1:0] arr_wdata;
  logic              line_valid;
  logic              line_dirty;
  logic [TAG_W-1:0]  line_tag;
  logic [LINE_W-1:0] line_data;

  cache_array #(
    .SETS       (SETS),
    .LINE_BYTES (LINE_BYTES),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .idx    (idx),
    .we     (arr_we),
    .wdirty (arr_wdirty),
    .wtag   (arr_wtag),
    .wdata  (arr_wdata),
    .valid  (line_valid),
    .dirty  (line_dirty),
    .tag    (line_tag),
    .data   (line_data)
  );

  logic req;
  logic hit;
  assign req = bus.mem_read | bus.mem_write;
  assign hit = line_valid && (line_tag == req_tag);

  // Byte merge of CPU write data into the resident line.
  logic [LINE_W-1:0] merged_line;
  always_comb begin
    merged_line = line_data;
    if (bus.mem_byte_enable[0]) merged_line[lo_bit +: 8] = bus.mem_wdata[7:0];
    if (bus.mem_byte_enable[1]) merged_line[hi_bit +: 8] = bus.mem_wdata[15:8];
  end

  // Combinational bus outputs
  logic              mem_resp_c;
  lc3b_word          mem_rdata_c;
  logic              pmem_read_c;
  logic              pmem_write_c;
  lc3b_word          pmem_address_c;
  logic [LINE_W-1:0] pmem_wdata_c;
  logic              hit_inc;
  logic              miss_inc;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, bus outputs and array write control
  always_comb begin
    state_d        = state_q;
    mem_resp_c     = 1'b0;
    mem_rdata_c    = '0;
    pmem_read_c    = 1'b0;
    pmem_write_c   = 1'b0;
    pmem_address_c = '0;
    pmem_wdata_c   = '0;
    arr_we         = 1'b0;
    arr_wdirty     = 1'b0;
    arr_wtag       = req_tag;
    arr_wdata      = merged_line;
    hit_inc        = 1'b0;
    miss_inc       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp_c = 1'b1;
            hit_inc    = 1'b1;
            // A simultaneous read and write is handled as a write.
            if (bus.mem_write) begin
              arr_we     = 1'b1;
              arr_wdirty = 1'b1;
              arr_wdata  = merged_line;
            end else begin
              mem_rdata_c = line_data[lo_bit +: 16];
            end
          end else begin
            miss_inc = 1'b1;
            state_d  = (line_valid && line_dirty) ? WRITEBACK : FILL;
          end
        end
      end

      WRITEBACK: begin
        pmem_write_c   = 1'b1;
        pmem_address_c = {line_tag, idx, {OFF{1'b0}}};
        pmem_wdata_c   = line_data;
        if (bus.pmem_resp) state_d = FILL;
      end

      FILL: begin
        pmem_read_c    = 1'b1;
        pmem_address_c = {req_tag, idx, {OFF{1'b0}}};
        if (bus.pmem_resp) begin
          arr_we     = 1'b1;
          arr_wdirty = 1'b0;
          arr_wtag   = req_tag;
          arr_wdata  = bus.pmem_rdata;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_resp     = mem_resp_c;
  assign bus.mem_rdata    = mem_rdata_c;
  assign bus.pmem_read    = pmem_read_c;
  assign bus.pmem_write   = pmem_write_c;
  assign bus.pmem_address = pmem_address_c;
  assign bus.pmem_wdata   = pmem_wdata_c;

  // Saturating statistics counters
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_inc && (hit_count != {CNT_W{1'b1}}))
        hit_count <= hit_count + CNT_W'(1);
      if (miss_inc && (miss_count != {CNT_W{1'b1}}))
        miss_count <= miss_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_lc3b_cache.sv
// Directed bench for lc3b_cache: a 16-bit-counter instance driven by the
// bench plus a 4-bit-counter instance shadowing the same traffic.
module tb_lc3b_cache;
  import lc3b_types::*;

  localparam int unsigned LB = 16;
  localparam int unsigned LW = 8 * LB;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lc3b_cache_if #(.LINE_BYTES(LB)) bus ();
  lc3b_cache_if #(.LINE_BYTES(LB)) bus2 ();

  logic [15:0] hit_count, miss_count;
  logic [3:0]  hit_count2, miss_count2;

  lc3b_cache #(.SETS(8), .LINE_BYTES(LB), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  lc3b_cache #(.SETS(8), .LINE_BYTES(LB), .CNT_W(4)) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus2),
    .hit_count  (hit_count2),
    .miss_count (miss_count2)
  );

  // Second instance sees identical inputs and so runs in lockstep.
  assign bus2.mem_read        = bus.mem_read;
  assign bus2.mem_write       = bus.mem_write;
  assign bus2.mem_address     = bus.mem_address;
  assign bus2.mem_wdata       = bus.mem_wdata;
  assign bus2.mem_byte_enable = bus.mem_byte_enable;
  assign bus2.pmem_rdata      = bus.pmem_rdata;
  assign bus2.pmem_resp       = bus.pmem_resp;

  logic [LW-1:0] pmem_model [4096];

  int n_cmp = 0;
  int n_bad = 0;

  int            n_prd, n_pwr;
  logic [15:0]   last_rd_addr, last_wr_addr;
  logic [LW-1:0] last_wr_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One CPU transaction, started at a falling edge; services pmem with a
  // two-cycle latency and returns the read data and the wait-cycle count.
  task automatic access(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [1:0] be,
                        output logic [15:0] rdata, output int cycles);
    int  lat;
    bit  done;
    lat    = 0;
    done   = 0;
    rdata  = '0;
    cycles = -1;
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_address     = addr;
    bus.mem_wdata       = wdata;
    bus.mem_byte_enable = be;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (bus.mem_resp) begin
        rdata  = bus.mem_rdata;
        cycles = c;
        done   = 1;
      end else if (bus.pmem_read || bus.pmem_write) begin
        if (lat == 0) begin
          if (bus.pmem_write) begin
            n_pwr++;
            last_wr_addr = bus.pmem_address;
            last_wr_data = bus.pmem_wdata;
          end else begin
            n_prd++;
            last_rd_addr = bus.pmem_address;
          end
        end
        lat++;
        if (lat == 2) begin
          if (bus.pmem_write) pmem_model[bus.pmem_address[15:4]] = bus.pmem_wdata;
          else                bus.pmem_rdata = pmem_model[bus.pmem_address[15:4]];
          bus.pmem_resp = 1'b1;
          lat = 0;
        end
      end
      @(negedge clk);
      bus.pmem_resp = 1'b0;
    end
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    if (!done) check("access_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic        chk;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs [12];
  logic [15:0] rdata;
  int          cycles;

  initial begin
    // All hits on the resident line 0x0010..0x001F (word w initially 0xC010+w).
    vecs[0]  = '{1'b1, 1'b0, 16'h0012, 16'h0000, 2'b00, 1'b1, 16'hBEEF};
    vecs[1]  = '{1'b0, 1'b1, 16'h0012, 16'hAB00, 2'b10, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 16'h0012, 16'h0000, 2'b00, 1'b1, 16'hABEF};
    vecs[3]  = '{1'b0, 1'b1, 16'h0014, 16'h1234, 2'b01, 1'b0, 16'h0000};
    vecs[4]  = '{1'b1, 1'b0, 16'h0014, 16'h0000, 2'b00, 1'b1, 16'hC034};
    vecs[5]  = '{1'b0, 1'b1, 16'h001E, 16'h5678, 2'b11, 1'b0, 16'h0000};
    vecs[6]  = '{1'b1, 1'b0, 16'h001E, 16'h0000, 2'b00, 1'b1, 16'h5678};
    vecs[7]  = '{1'b0, 1'b1, 16'h0010, 16'hFFFF, 2'b00, 1'b0, 16'h0000};
    vecs[8]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 1'b1, 16'hC010};
    vecs[9]  = '{1'b1, 1'b1, 16'h0016, 16'h9999, 2'b11, 1'b0, 16'h0000};
    vecs[10] = '{1'b1, 1'b0, 16'h0016, 16'h0000, 2'b00, 1'b1, 16'h9999};
    vecs[11] = '{1'b1, 1'b0, 16'h0013, 16'h0000, 2'b00, 1'b1, 16'hABEF};

    for (int n = 0; n < 4096; n++)
      for (int w = 0; w < 8; w++)
        pmem_model[n][16*w +: 16] = 16'hC000 | 16'(n * 16 + w);
    pmem_model[1][31:16] = 16'hBEEF;

    n_prd = 0;
    n_pwr = 0;
    last_rd_addr = '0;
    last_wr_addr = '0;
    last_wr_data = '0;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_address     = '0;
    bus.mem_wdata       = '0;
    bus.mem_byte_enable = '0;
    bus.pmem_rdata      = '0;
    bus.pmem_resp       = 1'b0;

    // Reset state
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_resp",   32'(bus.mem_resp),   32'd0);
    check("rst_pmem_read",  32'(bus.pmem_read),  32'd0);
    check("rst_pmem_write", 32'(bus.pmem_write), 32'd0);
    check("rst_hit_count",  32'(hit_count),      32'd0);
    check("rst_miss_count", 32'(miss_count),     32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Cold read: clean miss, fill, then hit
    access(1'b1, 1'b0, 16'h0012, 16'h0, 2'b00, rdata, cycles);
    check("cold_rdata",     32'(rdata),        32'hBEEF);
    check("cold_cycles",    32'(cycles),       32'd3);
    check("cold_fill_addr", 32'(last_rd_addr), 32'h0010);
    check("cold_n_prd",     32'(n_prd),        32'd1);
    check("cold_miss",      32'(miss_count),   32'd1);
    check("cold_hit",       32'(hit_count),    32'd1);

    // Hit vectors
    for (int i = 0; i < 12; i++) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, rdata, cycles);
      check($sformatf("vec%0d_cycles", i), 32'(cycles), 32'd0);
      if (vecs[i].chk) check($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vecs[i].exp));
    end
    check("vec_hit_count",  32'(hit_count),  32'd13);
    check("vec_miss_count", 32'(miss_count), 32'd1);
    check("vec_no_pmem",    32'(n_prd + n_pwr), 32'd1);

    // Dirty conflict miss: writeback then fill
    access(1'b1, 1'b0, 16'h0092, 16'h0, 2'b00, rdata, cycles);
    check("wb_rdata",     32'(rdata),              32'hC091);
    check("wb_cycles",    32'(cycles),             32'd5);
    check("wb_n_pwr",     32'(n_pwr),              32'd1);
    check("wb_addr",      32'(last_wr_addr),       32'h0010);
    check("wb_word0",     32'(last_wr_data[15:0]),   32'hC010);
    check("wb_word1",     32'(last_wr_data[31:16]),  32'hABEF);
    check("wb_word2",     32'(last_wr_data[47:32]),  32'hC034);
    check("wb_word3",     32'(last_wr_data[63:48]),  32'h9999);
    check("wb_word7",     32'(last_wr_data[127:112]), 32'h5678);
    check("wb_fill_addr", 32'(last_rd_addr),       32'h0090);
    check("wb_miss",      32'(miss_count),         32'd2);
    check("wb_hit",       32'(hit_count),          32'd14);

    // Reset during FILL abandons the fill
    bus.mem_read    = 1'b1;
    bus.mem_address = 16'h0012;
    #1;
    check("abort_idle_pmem", 32'(bus.pmem_read), 32'd0);
    @(negedge clk);
    #1;
    check("abort_fill_pmem", 32'(bus.pmem_read), 32'd1);
    bus.mem_read = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("abort_pmem_read",  32'(bus.pmem_read),  32'd0);
    check("abort_pmem_write", 32'(bus.pmem_write), 32'd0);
    check("abort_mem_resp",   32'(bus.mem_resp),   32'd0);
    check("abort_miss",       32'(miss_count),     32'd0);
    check("abort_hit",        32'(hit_count),      32'd0);
    reset = 1'b0;
    @(negedge clk);

    access(1'b1, 1'b0, 16'h0012, 16'h0, 2'b00, rdata, cycles);
    check("post_rst_rdata",  32'(rdata),      32'hABEF);
    check("post_rst_cycles", 32'(cycles),     32'd3);
    check("post_rst_n_pwr",  32'(n_pwr),      32'd1);
    check("post_rst_miss",   32'(miss_count), 32'd1);
    check("post_rst_hit",    32'(hit_count),  32'd1);

    // Counter saturation on the 4-bit instance
    for (int i = 0; i < 20; i++) begin
      access(1'b1, 1'b0, 16'h0012, 16'h0, 2'b00, rdata, cycles);
      if (i == 13) check("sat_reach_15", 32'(hit_count2), 32'd15);
    end
    check("sat_hit_count2",  32'(hit_count2),  32'd15);
    check("sat_miss_count2", 32'(miss_count2), 32'd1);
    check("sat_hit_count",   32'(hit_count),   32'd21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
